// File: rtl/calendar_sequencer.sv
// Calendar sequencer: prescaled day-advance tick driving a month / BCD day /
// day-of-year register set, with run/pause, slow/fast rate, leap-year month
// lengths and a validated two-step date load (capture, then LOAD cycle).
module calendar_sequencer #(
  parameter int DIV_SLOW   = 5_000_000,
  parameter int DIV_FAST   = 2_000_000,
  parameter int LAST_MONTH = 4
) (
  input  logic       ADC_CLK_10,
  input  logic       reset,
  input  logic       run,
  input  logic       fast_sel,
  input  logic       leap_year,
  input  logic       set_req,
  input  logic [3:0] set_month,
  input  logic [7:0] set_day,
  output logic [3:0] month,
  output logic [7:0] day_bcd,
  output logic [8:0] doy,
  output logic       tick,
  output logic       wrap,
  output logic       set_err
);

  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int CW      = $clog2(DIV_MAX + 1);

  typedef enum logic [1:0] {PAUSE, RUN, LOAD} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    month_q, pend_month_q;
  logic [7:0]    day_q, pend_day_q;
  logic [8:0]    doy_q;
  logic          tick_q, wrap_q, set_err_q;

  logic [CW-1:0] div_m1_d;
  logic          set_ok_d;
  logic [3:0]    adv_month_d;
  logic [7:0]    adv_day_d;
  logic          adv_wrap_d;
  logic [8:0]    adv_doy_d, load_doy_d;

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                      month_len = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   month_len = 5'd30;
      default:                   month_len = 5'd31;
    endcase
  endfunction

  function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
    bcd_to_bin = {3'b000, b[7:4]} * 7'd10 + {3'b000, b[3:0]};
  endfunction

  // Days before the first of month m; the leap day counts from March onwards.
  function automatic logic [8:0] cum_days(input logic [3:0] m, input logic leap);
    logic [8:0] base;
    case (m)
      4'd2:    base = 9'd31;
      4'd3:    base = 9'd59;
      4'd4:    base = 9'd90;
      4'd5:    base = 9'd120;
      4'd6:    base = 9'd151;
      4'd7:    base = 9'd181;
      4'd8:    base = 9'd212;
      4'd9:    base = 9'd243;
      4'd10:   base = 9'd273;
      4'd11:   base = 9'd304;
      4'd12:   base = 9'd334;
      default: base = 9'd0;
    endcase
    cum_days = base + {8'd0, (leap && (m > 4'd2))};
  endfunction

  function automatic logic [8:0] doy_calc(input logic [3:0] m, input logic [7:0] d,
                                          input logic leap);
    doy_calc = cum_days(m, leap) + {2'b00, bcd_to_bin(d)};
  endfunction

  // Rate select, set validation and the candidate next date for an advance.
  always_comb begin
    div_m1_d    = fast_sel ? CW'(DIV_FAST - 1) : CW'(DIV_SLOW - 1);
    set_ok_d    = (set_month >= 4'd1) && (set_month <= 4'(LAST_MONTH)) &&
                  (set_day[7:4] <= 4'd9) && (set_day[3:0] <= 4'd9) &&
                  (bcd_to_bin(set_day) != 7'd0) &&
                  (bcd_to_bin(set_day) <= {2'b00, month_len(set_month, leap_year)});
    adv_month_d = month_q;
    adv_day_d   = 8'h01;
    adv_wrap_d  = 1'b0;
    // ">=" rather than "==" so a Feb 29 left behind by clearing leap_year rolls to Mar 01.
    if (bcd_to_bin(day_q) < {2'b00, month_len(month_q, leap_year)}) begin
      adv_day_d = (day_q[3:0] == 4'd9) ? {day_q[7:4] + 4'd1, 4'd0}
                                       : {day_q[7:4], day_q[3:0] + 4'd1};
    end else if (month_q < 4'(LAST_MONTH)) begin
      adv_month_d = month_q + 4'd1;
    end else begin
      adv_month_d = 4'd1;
      adv_wrap_d  = 1'b1;
    end
    adv_doy_d  = doy_calc(adv_month_d, adv_day_d, leap_year);
    load_doy_d = doy_calc(pend_month_q, pend_day_q, leap_year);
  end

  // Control FSM with prescaler, date registers and registered status pulses.
  always_ff @(posedge ADC_CLK_10 or posedge reset) begin
    if (reset) begin
      state_q      <= PAUSE;
      cnt_q        <= '0;
      month_q      <= 4'd1;
      day_q        <= 8'h01;
      doy_q        <= 9'd1;
      pend_month_q <= 4'd1;
      pend_day_q   <= 8'h01;
      tick_q       <= 1'b0;
      wrap_q       <= 1'b0;
      set_err_q    <= 1'b0;
    end else begin
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      set_err_q <= 1'b0;
      if (state_q == LOAD) begin
        month_q <= pend_month_q;
        day_q   <= pend_day_q;
        doy_q   <= load_doy_d;
        cnt_q   <= '0;
        state_q <= run ? RUN : PAUSE;
      end
      if (set_req) begin
        // A set request always pre-empts counting and any advance on this edge.
        if (set_ok_d) begin
          pend_month_q <= set_month;
          pend_day_q   <= set_day;
          state_q      <= LOAD;
        end else begin
          set_err_q <= 1'b1;
        end
      end else if (state_q != LOAD) begin
        state_q <= run ? RUN : PAUSE;
        if (run) begin
          if (cnt_q >= div_m1_d) begin
            cnt_q   <= '0;
            month_q <= adv_month_d;
            day_q   <= adv_day_d;
            doy_q   <= adv_doy_d;
            tick_q  <= 1'b1;
            wrap_q  <= adv_wrap_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign month   = month_q;
  assign day_bcd = day_q;
  assign doy     = doy_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign set_err = set_err_q;

endmodule

// File: tb/tb_calendar_sequencer.sv
// Testbench for calendar_sequencer: directed scenarios with literal expectations,
// then randomized stimulus, all compared every cycle against a date-level model.
module tb_calendar_sequencer;

  localparam int DS = 4;
  localparam int DF = 2;
  localparam int LM = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0, fast_sel = 1'b0, leap_year = 1'b0, set_req = 1'b0;
  logic [3:0] set_month = 4'd1;
  logic [7:0] set_day = 8'h01;
  logic [3:0] month;
  logic [7:0] day_bcd;
  logic [8:0] doy;
  logic       tick, wrap, set_err;

  int vectors = 0;
  int miscompares = 0;

  calendar_sequencer #(.DIV_SLOW(DS), .DIV_FAST(DF), .LAST_MONTH(LM)) dut (
    .ADC_CLK_10(clk), .reset(reset), .run(run), .fast_sel(fast_sel),
    .leap_year(leap_year), .set_req(set_req), .set_month(set_month),
    .set_day(set_day), .month(month), .day_bcd(day_bcd), .doy(doy),
    .tick(tick), .wrap(wrap), .set_err(set_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model (plain integers) ----------------
  int m_month, m_day, m_doy, m_cnt, p_month, p_day;
  bit m_load, e_tick, e_wrap, e_err;

  function automatic int mlen(input int m, input bit leap);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 31;
    return t[m-1] + ((m == 2 && leap) ? 1 : 0);
  endfunction

  function automatic int doy_of(input int m, input int d, input bit leap);
    int s = d;
    for (int k = 1; k < m; k++) s += mlen(k, leap);
    return s;
  endfunction

  function automatic bit valid_set(input int m, input logic [7:0] d, input bit leap);
    int tens = int'(d[7:4]);
    int ones = int'(d[3:0]);
    int dv = tens * 10 + ones;
    return (m >= 1) && (m <= LM) && (tens <= 9) && (ones <= 9) && (dv >= 1) &&
           (dv <= mlen(m, leap));
  endfunction

  function automatic logic [7:0] to_bcd(input int d);
    logic [3:0] t = 4'(d / 10);
    logic [3:0] o = 4'(d % 10);
    return {t, o};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_month = 1; m_day = 1; m_doy = 1; m_cnt = 0; m_load = 0;
      p_month = 1; p_day = 1;
      e_tick = 0; e_wrap = 0; e_err = 0;
    end else begin
      e_tick = 0; e_wrap = 0; e_err = 0;
      if (m_load) begin
        m_month = p_month; m_day = p_day;
        m_doy = doy_of(m_month, m_day, leap_year);
        m_cnt = 0;
      end
      if (set_req) begin
        if (valid_set(int'(set_month), set_day, leap_year)) begin
          p_month = int'(set_month);
          p_day = int'(set_day[7:4]) * 10 + int'(set_day[3:0]);
          m_load = 1;
        end else begin
          e_err = 1;
          m_load = 0;
        end
      end else if (m_load) begin
        m_load = 0;
      end else if (run) begin
        if (m_cnt >= (fast_sel ? DF : DS) - 1) begin
          m_cnt = 0;
          e_tick = 1;
          if (m_day < mlen(m_month, leap_year)) m_day++;
          else if (m_month < LM) begin m_month++; m_day = 1; end
          else begin m_month = 1; m_day = 1; e_wrap = 1; end
          m_doy = doy_of(m_month, m_day, leap_year);
        end else begin
          m_cnt++;
        end
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle compare of every output against the model, away from the active edge.
  always @(negedge clk) begin
    cmp("month", int'(month), m_month);
    cmp("day_bcd", int'(day_bcd), int'(to_bcd(m_day)));
    cmp("doy", int'(doy), m_doy);
    cmp("tick", int'(tick), int'(e_tick));
    cmp("wrap", int'(wrap), int'(e_wrap));
    cmp("set_err", int'(set_err), int'(e_err));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_set(input logic [3:0] m, input logic [7:0] d);
    set_month = m; set_day = d; set_req = 1'b1;
    step();
    set_req = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    do begin step(); n++; end while (tick !== 1'b1 && n < 40);
    vectors++;
    if (tick !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: tick not seen within 40 cycles", tag);
    end
  endtask

  task automatic chk_date(input string tag, input int m, input int d, input int y);
    cmp({tag, ".month"}, int'(month), m);
    cmp({tag, ".day"}, int'(day_bcd), d);
    cmp({tag, ".doy"}, int'(doy), y);
  endtask

  // ---------------- directed then random stimulus ----------------
  initial begin
    int cool;
    step(); step();
    reset = 1'b0;
    chk_date("rst", 1, 'h01, 1);
    cmp("rst.tick", int'(tick), 0);

    // 1: first tick four clocks after run
    run = 1'b1;
    step(); step(); step();
    cmp("t1.notick", int'(tick), 0);
    step();
    cmp("t1.tick", int'(tick), 1);
    chk_date("t1", 1, 'h02, 2);

    // 2: month roll and BCD carry
    pulse_set(4'd1, 8'h31);
    wait_tick("t2a");
    chk_date("t2a", 2, 'h01, 32);
    pulse_set(4'd1, 8'h09);
    wait_tick("t2b");
    chk_date("t2b", 1, 'h10, 10);

    // 3: leap day, then clearing leap rolls Feb 29 to Mar 01
    leap_year = 1'b1;
    pulse_set(4'd2, 8'h28);
    wait_tick("t3a");
    chk_date("t3a", 2, 'h29, 60);
    leap_year = 1'b0;
    wait_tick("t3b");
    chk_date("t3b", 3, 'h01, 60);

    // 4: wrap from the last month
    pulse_set(4'd4, 8'h30);
    wait_tick("t4");
    chk_date("t4", 1, 'h01, 1);
    cmp("t4.wrap", int'(wrap), 1);

    // 5: rejected sets
    run = 1'b0;
    leap_year = 1'b1;
    step();
    pulse_set(4'd2, 8'h30);
    cmp("t5a.err", int'(set_err), 1);
    pulse_set(4'd5, 8'h01);
    cmp("t5b.err", int'(set_err), 1);
    pulse_set(4'd1, 8'h1A);
    cmp("t5c.err", int'(set_err), 1);
    step();
    chk_date("t5", 1, 'h01, 1);
    leap_year = 1'b0;

    // 6a: set on the advance edge drops the tick
    run = 1'b1;
    wait_tick("t6a");
    step(); step(); step();
    pulse_set(4'd3, 8'h15);
    cmp("t6a.notick", int'(tick), 0);
    step();
    cmp("t6a.notick2", int'(tick), 0);
    chk_date("t6a", 3, 'h15, 74);

    // 6b: switching to fast with the count already past the fast limit
    wait_tick("t6b");
    step(); step();
    fast_sel = 1'b1;
    step();
    cmp("t6b.tick", int'(tick), 1);
    chk_date("t6b", 3, 'h17, 76);
    fast_sel = 1'b0;

    // 6c: reset while in LOAD
    pulse_set(4'd2, 8'h14);
    reset = 1'b1;
    #1;
    chk_date("t6c", 1, 'h01, 1);
    step();
    reset = 1'b0;

    // randomized phase
    cool = 0;
    for (int i = 0; i < 4000; i++) begin
      step();
      reset = ($urandom_range(0, 599) == 0);
      run = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) fast_sel = ~fast_sel;
      if ($urandom_range(0, 59) == 0) leap_year = ~leap_year;
      if (cool > 0) cool--;
      if (cool == 0 && $urandom_range(0, 14) == 0) begin
        set_req = 1'b1;
        set_month = 4'($urandom_range(0, 6));
        set_day = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 10))};
        cool = 2;
      end else begin
        set_req = 1'b0;
      end
    end
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
